// File: rtl/sbox_pkg.sv
// sbox_pkg: shared types and the power-on table contents for sbox_lut_pipe.
//   state_t        : table controller states (ST_INIT reloads the table, ST_RUN serves lookups)
//   default_entry  : value loaded into entry idx during ST_INIT
//                    IN_W=4/OUT_W=4 -> 0,3,6,7,C,F,E,D,A,F,E,D,A,8,9,B
//                    any other shape -> identity (idx truncated/zero-extended to out_w bits)
package sbox_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    function automatic logic [31:0] default_entry(input logic [31:0] idx,
                                                  input int unsigned in_w,
                                                  input int unsigned out_w);
        logic [31:0] res;
        logic [31:0] mask;
        mask = (out_w >= 32) ? '1 : ((32'd1 << out_w) - 32'd1);
        res  = idx & mask;
        if (in_w == 4 && out_w == 4) begin
            case (idx[3:0])
                4'h0:    res = 32'h0;
                4'h1:    res = 32'h3;
                4'h2:    res = 32'h6;
                4'h3:    res = 32'h7;
                4'h4:    res = 32'hC;
                4'h5:    res = 32'hF;
                4'h6:    res = 32'hE;
                4'h7:    res = 32'hD;
                4'h8:    res = 32'hA;
                4'h9:    res = 32'hF;
                4'hA:    res = 32'hE;
                4'hB:    res = 32'hD;
                4'hC:    res = 32'hA;
                4'hD:    res = 32'h8;
                4'hE:    res = 32'h9;
                default: res = 32'hB;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/sbox_table_ram.sv
// sbox_table_ram: 2**AW x DW register file backing the substitution table.
//   clk   in  : write clock
//   we    in  : write enable (synchronous)
//   waddr in  : write address
//   wdata in  : write data
//   raddr in  : read address
//   rdata out : combinational read of mem[raddr]; a write lands at the edge, so a read in
//               the same cycle as the write still sees the old word
module sbox_table_ram
    import sbox_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sbox_lut_pipe.sv
// sbox_lut_pipe: programmable IN_W -> OUT_W substitution table with a 2-stage
// valid/ready lookup pipeline and a self-initialising table loader.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : index handshake; in_ready is low while the table reloads
//   in_idx                : lookup index
//   out_valid/out_ready   : result handshake; result held while stalled
//   out_data              : table[idx]
//   out_perr              : stored parity mismatch on this result
//   cfg_we/addr/data      : runtime table write (ignored during reload)
//   cfg_perr_inj          : flips the stored parity of a cfg write (parity build only)
//   cfg_init              : pulse to reload the default table; wins over cfg_we
//   init_done             : table loaded and serving lookups
//   lookup_cnt            : completed lookups, saturating
// Build option: define SBOX_PARITY_EN to store an even-parity bit per entry and check it.
module sbox_lut_pipe
    import sbox_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_perr,
    input  logic             cfg_we,
    input  logic [IN_W-1:0]  cfg_addr,
    input  logic [OUT_W-1:0] cfg_data,
`ifdef SBOX_PARITY_EN
    input  logic             cfg_perr_inj,
`endif
    input  logic             cfg_init,
    output logic             init_done,
    output logic [CNT_W-1:0] lookup_cnt
);

`ifdef SBOX_PARITY_EN
    localparam int MEM_W = OUT_W + 1;
`else
    localparam int MEM_W = OUT_W;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    state_t            state_q, state_d;
    logic [IN_W-1:0]   ptr_q, ptr_d;
    logic              wr_en;
    logic [IN_W-1:0]   wr_addr;
    logic [OUT_W-1:0]  wr_data;
    logic [MEM_W-1:0]  wr_word, rd_word;
    logic              rd_perr;

    logic              run, s1_rdy, s2_rdy, acc_in, fire_out;
    logic              vld_p1, vld_p2;
    logic [IN_W-1:0]   idx_p1;
    logic [OUT_W-1:0]  data_p2;
    logic              perr_p2;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        wr_addr = ptr_q;
        wr_data = OUT_W'(default_entry(32'(ptr_q), IN_W, OUT_W));
        case (state_q)
            ST_INIT: begin
                wr_en = 1'b1;
                ptr_d = ptr_q + IN_W'(1);
                if (ptr_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cfg_init) begin
                    state_d = ST_INIT;
                    ptr_d   = '0;
                end else if (cfg_we) begin
                    wr_en   = 1'b1;
                    wr_addr = cfg_addr;
                    wr_data = cfg_data;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

`ifdef SBOX_PARITY_EN
    // Injection only applies to runtime writes, never to the reload sequence.
    assign wr_word = {(^wr_data) ^ (cfg_perr_inj && wr_en && (state_q == ST_RUN)), wr_data};
    assign rd_perr = ^rd_word;
`else
    assign wr_word = wr_data;
    assign rd_perr = 1'b0;
`endif

    sbox_table_ram #(
        .AW (IN_W),
        .DW (MEM_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_word),
        .raddr (idx_p1),
        .rdata (rd_word)
    );

    assign run      = (state_q == ST_RUN);
    assign s2_rdy   = !vld_p2 || out_ready;
    assign s1_rdy   = !vld_p1 || s2_rdy;
    assign in_ready = s1_rdy && run;
    assign acc_in   = in_valid && in_ready;
    assign fire_out = vld_p2 && out_ready;

    // ---- stage 1: capture index ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (s1_rdy) begin
            vld_p1 <= acc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_in) begin
            idx_p1 <= in_idx;
        end
    end

    // ---- stage 2: table read registered, parity checked ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            perr_p2 <= 1'b0;
        end else if (s2_rdy) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2 <= rd_word[OUT_W-1:0];
                perr_p2 <= rd_perr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (fire_out) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign out_valid  = vld_p2;
    assign out_data   = data_p2;
    assign out_perr   = perr_p2;
    assign init_done  = run;
    assign lookup_cnt = cnt_q;

endmodule
